// File: rtl/pixel_shifter.sv
// Parallel-to-serial pixel shifter: a one-word holding buffer feeds an MSB-first
// shift register that emits bpp bits per enabled pixel slot.
module pixel_shifter #(
  parameter int unsigned bits = 16,
  parameter int unsigned bpp  = 2
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            en,
  input  logic            blank,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [bits-1:0] d,
  output logic [bpp-1:0]  pix,
  output logic            pix_valid,
  output logic            underrun,
  input  logic            clr_underrun
);

  localparam int unsigned npix = bits / bpp;
  localparam int unsigned cw   = $clog2(npix + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  state_t          state_nx;
  logic [bits-1:0] hold;
  logic [bits-1:0] sr;
  logic            hold_full;
  logic [cw-1:0]   cnt;
  logic            running;

  logic have_sr;
  logic slot_data;
  logic preload;
  logic starve;
  logic ld_fire;
  logic underrun_set;

  assign have_sr      = (cnt != '0);
  assign slot_data    = en && (have_sr || hold_full);
  assign preload      = !en && !have_sr && hold_full;
  assign starve       = en && !have_sr && !hold_full;
  // ld_fire needs !hold_full and every hold consumer needs hold_full, so they never collide
  assign ld_fire      = ld_valid && !hold_full && !blank;
  assign underrun_set = !blank && starve && running;

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (blank) begin
      state_nx = IDLE;
    end else if ((state == IDLE) && slot_data) begin
      state_nx = RUN;
    end
  end

  always_comb begin
    ld_ready = !hold_full;
    running  = (state == RUN);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      pix       <= '0;
      pix_valid <= 1'b0;
    end else if (blank) begin
      cnt       <= '0;
      hold_full <= 1'b0;
      pix       <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (ld_fire) begin
        hold      <= d;
        hold_full <= 1'b1;
      end
      if (en) begin
        if (have_sr) begin
          pix       <= sr[bits-1 -: bpp];
          pix_valid <= 1'b1;
          sr        <= sr << bpp;
          cnt       <= cnt - cw'(1);
        end else if (hold_full) begin
          // first pixel comes straight from hold so back-to-back words leave no gap slot
          pix       <= hold[bits-1 -: bpp];
          pix_valid <= 1'b1;
          sr        <= hold << bpp;
          cnt       <= cw'(npix - 1);
          hold_full <= 1'b0;
        end else begin
          pix       <= '0;
          pix_valid <= 1'b0;
        end
      end else if (preload) begin
        sr        <= hold;
        cnt       <= cw'(npix);
        hold_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else if (underrun_set) begin
      underrun <= 1'b1;
    end else if (clr_underrun) begin
      underrun <= 1'b0;
    end
  end

endmodule
